gate_tester_ctrl: RTL and testbench

//  Sequencer that exhaustively exercises one 2-input combinational gate under test
//  (xor/nand/nor lab gates) from a single clocked controller.
//  - Drives all four {a,b} vectors in order and waits a programmable settle time.
//  - Samples the gate output and compares it against a 4-bit expected truth table.
//  - Reports pass/fail, mismatch count and the failing-vector mask over a start/busy/done handshake.

---
 rtl/gate_tester_pkg.sv | 25 ++
 rtl/gate_tester_settle_cnt.sv | 37 +++
 rtl/gate_tester_ctrl.sv | 160 ++++++++++++++++
 tb/tb_gate_tester_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/gate_tester_pkg.sv
// ---------------------------------------------------------------------------
// gate_tester_pkg
//   Shared types and constants for the 2-input gate tester controller.
//   - state_t  : controller state encoding
//   - SETTLE_W : width of the settle down-counter (SETTLE_CYCLES legal 0..15)
//   - TT_*     : expected truth tables, bit index = {a,b}
// ---------------------------------------------------------------------------
package gate_tester_pkg;

   localparam int unsigned SETTLE_W = 4;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_AND  = 4'b1000;

endpackage

// File: rtl/gate_tester_settle_cnt.sv
// ---------------------------------------------------------------------------
// gate_tester_settle_cnt
//   Loadable down-counter with a zero flag; times the SETTLE state.
//   Ports:
//     clk      in  clock, rising edge
//     rst      in  asynchronous active-high reset
//     load     in  load load_val (has priority over dec)
//     load_val in  value to load
//     dec      in  decrement by one, saturating at zero
//     zero     out counter equals zero
// ---------------------------------------------------------------------------
import gate_tester_pkg::*;

module gate_tester_settle_cnt (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [SETTLE_W-1:0] load_val,
   input  logic                dec,
   output logic                zero
);

   logic [SETTLE_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/gate_tester_ctrl.sv
// ---------------------------------------------------------------------------
// gate_tester_ctrl
//   Sequencer that drives all four {a,b} vectors into a 2-input gate under
//   test, waits SETTLE_CYCLES after each, samples dut_y and compares it with
//   the truth table latched at start.
//   Parameters:
//     SETTLE_CYCLES  settle cycles between DRIVE and SAMPLE (0..15)
//   Ports:
//     clk, rst   clock / asynchronous active-high reset
//     start      run request, honoured only in IDLE
//     exp_tt     expected truth table, bit index {a,b}, latched at start
//     dut_y      gate output
//     tst_a/b    registered gate inputs
//     busy       high from the cycle after start acceptance through DONE
//     done       one-cycle completion pulse
//     pass       err_cnt == 0, held until next start
//     err_cnt    mismatching vector count, held
//     fail_vec   per-vector mismatch mask, held
//     obs_tt     (GATE_TESTER_OBS_EN only) observed dut_y per vector
//   Build option: define GATE_TESTER_OBS_EN to add obs_tt.
// ---------------------------------------------------------------------------
import gate_tester_pkg::*;

module gate_tester_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] exp_tt,
   input  logic       dut_y,
   output logic       tst_a,
   output logic       tst_b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_cnt,
   output logic [3:0] fail_vec
`ifdef GATE_TESTER_OBS_EN
   ,
   output logic [3:0] obs_tt
`endif
);

   // DRIVE loads SETTLE_CYCLES-1 so SETTLE lasts exactly SETTLE_CYCLES cycles
   // (the counter reads zero during the last SETTLE cycle).
   localparam logic [SETTLE_W-1:0] SETTLE_LOAD =
      (SETTLE_CYCLES == 0) ? '0 : SETTLE_W'(SETTLE_CYCLES - 1);

   state_t      state, next_state;
   logic [1:0]  v;
   logic [3:0]  exp_q;
   logic        cnt_load;
   logic        cnt_dec;
   logic        cnt_zero;
   logic        mism;
   logic [2:0]  err_nxt;

   gate_tester_settle_cnt u_settle_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (SETTLE_LOAD),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (start) next_state = DRIVE;
         DRIVE:   next_state = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
         SETTLE:  if (cnt_zero) next_state = SAMPLE;
         SAMPLE:  next_state = (v == 2'd3) ? DONE : DRIVE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      busy     = (state != IDLE);
      done     = (state == DONE);
      cnt_load = (state == DRIVE);
      cnt_dec  = (state == SETTLE);
   end

   // Case inequality so an X/Z gate output is flagged as a mismatch.
   always_comb begin
      mism    = (dut_y !== exp_q[v]);
      err_nxt = err_cnt + {2'b00, mism};
   end

   // Datapath: vector index, gate drive and result registers.
   // tst_a/tst_b are loaded on the edge entering DRIVE so the gate sees the
   // new vector for the whole DRIVE/SETTLE/SAMPLE window; pass is computed
   // from err_nxt on the last sample so it is already valid during DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q    <= '0;
         v        <= '0;
         tst_a    <= 1'b0;
         tst_b    <= 1'b0;
         pass     <= 1'b0;
         err_cnt  <= '0;
         fail_vec <= '0;
`ifdef GATE_TESTER_OBS_EN
         obs_tt   <= '0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  exp_q    <= exp_tt;
                  v        <= '0;
                  tst_a    <= 1'b0;
                  tst_b    <= 1'b0;
                  pass     <= 1'b0;
                  err_cnt  <= '0;
                  fail_vec <= '0;
`ifdef GATE_TESTER_OBS_EN
                  obs_tt   <= '0;
`endif
               end
            end
            SAMPLE: begin
               if (mism) begin
                  fail_vec[v] <= 1'b1;
               end
               err_cnt <= err_nxt;
`ifdef GATE_TESTER_OBS_EN
               obs_tt[v] <= dut_y;
`endif
               if (v == 2'd3) begin
                  tst_a <= 1'b0;
                  tst_b <= 1'b0;
                  pass  <= (err_nxt == '0);
               end else begin
                  v     <= v + 2'd1;
                  tst_a <= (v + 2'd1) >> 1;
                  tst_b <= v[0] ^ 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_tester_ctrl.sv
// Self-checking bench: two controllers (SETTLE_CYCLES=2 and 0) each driving a
// behavioural gate whose truth table is chosen per run.
`timescale 1ns/1ps
import gate_tester_pkg::*;

module tb_gate_tester_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [3:0] gate_tt;
   logic       start0, start1;
   logic [3:0] exp0, exp1;
   logic       a0, b0, a1, b1, y0, y1;
   logic       busy0, busy1, done0, done1, pass0, pass1;
   logic [2:0] err0, err1;
   logic [3:0] fv0, fv1;
`ifdef GATE_TESTER_OBS_EN
   logic [3:0] obs0, obs1;
`endif

   assign y0 = gate_tt[{a0, b0}];
   assign y1 = gate_tt[{a1, b1}];

   gate_tester_ctrl #(.SETTLE_CYCLES(2)) u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .exp_tt(exp0), .dut_y(y0),
      .tst_a(a0), .tst_b(b0), .busy(busy0), .done(done0), .pass(pass0),
      .err_cnt(err0), .fail_vec(fv0)
`ifdef GATE_TESTER_OBS_EN
      , .obs_tt(obs0)
`endif
   );

   gate_tester_ctrl #(.SETTLE_CYCLES(0)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .exp_tt(exp1), .dut_y(y1),
      .tst_a(a1), .tst_b(b1), .busy(busy1), .done(done1), .pass(pass1),
      .err_cnt(err1), .fail_vec(fv1)
`ifdef GATE_TESTER_OBS_EN
      , .obs_tt(obs1)
`endif
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] want);
      n_cmp++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   function automatic logic [1:0] tst_of(input int sel);
      return (sel != 0) ? {a1, b1} : {a0, b0};
   endfunction
   function automatic logic busy_of(input int sel);
      return (sel != 0) ? busy1 : busy0;
   endfunction
   function automatic logic done_of(input int sel);
      return (sel != 0) ? done1 : done0;
   endfunction
   function automatic logic pass_of(input int sel);
      return (sel != 0) ? pass1 : pass0;
   endfunction
   function automatic logic [2:0] err_of(input int sel);
      return (sel != 0) ? err1 : err0;
   endfunction
   function automatic logic [3:0] fv_of(input int sel);
      return (sel != 0) ? fv1 : fv0;
   endfunction

   task automatic set_start(input int sel, input logic val);
      if (sel != 0) start1 = val; else start0 = val;
   endtask
   task automatic set_exp(input int sel, input logic [3:0] val);
      if (sel != 0) exp1 = val; else exp0 = val;
   endtask

   function automatic int unsigned ones4(input logic [3:0] x);
      int unsigned n = 0;
      for (int unsigned i = 0; i < 4; i++) n += x[i];
      return n;
   endfunction

   // One complete run. Reference: each vector v is presented for
   // (settle+2) cycles in order 0..3, done follows 4*(settle+2) edges after
   // acceptance, mismatches are the bits where gate and expectation differ.
   // hold must be >= 1 so the controller is back in IDLE before the next run.
   task automatic run(input int sel, input logic [3:0] expv, input logic [3:0] gate,
                      input int hold, input bit disturb);
      int unsigned per = ((sel != 0) ? 0 : 2) + 2;
      int unsigned lat = 4 * per;
      logic [3:0]  want_fv = gate ^ expv;
      logic [2:0]  want_err = 3'(ones4(want_fv));
      logic        want_pass = (want_fv == 4'b0000);
      gate_tt = gate;
      set_exp(sel, expv);
      set_start(sel, 1'b1);
      @(posedge clk); #1;
      set_start(sel, 1'b0);
      for (int unsigned i = 0; i < lat; i++) begin
         check("tst_vec", 8'(tst_of(sel)), 8'(i / per));
         check("busy_run", 8'(busy_of(sel)), 8'd1);
         check("done_early", 8'(done_of(sel)), 8'd0);
         if (disturb && i == 5) begin
            set_start(sel, 1'b1);
            set_exp(sel, ~expv);
         end
         if (disturb && i == 6) set_start(sel, 1'b0);
         @(posedge clk); #1;
      end
      check("done_pulse", 8'(done_of(sel)), 8'd1);
      check("busy_done", 8'(busy_of(sel)), 8'd1);
      check("tst_done", 8'(tst_of(sel)), 8'd0);
      check("pass", 8'(pass_of(sel)), 8'(want_pass));
      check("err_cnt", 8'(err_of(sel)), 8'(want_err));
      check("fail_vec", 8'(fv_of(sel)), 8'(want_fv));
`ifdef GATE_TESTER_OBS_EN
      check("obs_tt", 8'((sel != 0) ? obs1 : obs0), 8'(gate));
`endif
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check("done_after", 8'(done_of(sel)), 8'd0);
         check("busy_after", 8'(busy_of(sel)), 8'd0);
         check("pass_held", 8'(pass_of(sel)), 8'(want_pass));
         check("err_held", 8'(err_of(sel)), 8'(want_err));
         check("fv_held", 8'(fv_of(sel)), 8'(want_fv));
      end
   endtask

   // Global time limit in case a run loop never returns.
   initial begin
      #2ms;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
      exp0 = '0; exp1 = '0; gate_tt = TT_XOR;
      #1;
      check("rst_busy0", 8'(busy0), 8'd0);
      check("rst_done0", 8'(done0), 8'd0);
      check("rst_tst0", 8'({a0, b0}), 8'd0);
      check("rst_res0", 8'({pass0, err0, fv0}), 8'd0);
      check("rst_busy1", 8'(busy1), 8'd0);
      check("rst_res1", 8'({pass1, err1, fv1}), 8'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // 1: XOR gate, XOR expectation
      run(0, TT_XOR, TT_XOR, 2, 1'b0);
      // 2: stuck-at-0 gate
      run(0, TT_XOR, 4'b0000, 2, 1'b0);
      // 3: XOR gate, NAND expectation, results held 20 cycles
      run(0, TT_NAND, TT_XOR, 20, 1'b0);

      // 4: reset during vector 2 SETTLE
      gate_tt = TT_XOR; exp0 = TT_XOR; start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      check("v2_before_rst", 8'({a0, b0}), 8'd2);
      rst = 1'b1;
      #1;
      check("rst_mid_tst", 8'({a0, b0}), 8'd0);
      check("rst_mid_busy", 8'(busy0), 8'd0);
      check("rst_mid_done", 8'(done0), 8'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(posedge clk); #1;
         check("no_done_after_rst", 8'(done0), 8'd0);
      end
      run(0, TT_XOR, TT_XOR, 1, 1'b0);

      // 5a: start held high for 40 edges -> runs accepted every 4*4+2 edges
      gate_tt = TT_XOR; exp0 = TT_XOR; start0 = 1'b1;
      for (int t = 0; t < 60; t++) begin
         int  j;
         bit  want_done, want_busy;
         @(posedge clk); #1;
         want_done = 1'b0; want_busy = 1'b0;
         for (j = 0; 18 * j <= 39; j++) begin
            if (t == 18 * j + 16) want_done = 1'b1;
            if (t >= 18 * j && t <= 18 * j + 16) want_busy = 1'b1;
         end
         check("held_done", 8'(done0), 8'(want_done));
         check("held_busy", 8'(busy0), 8'(want_busy));
         if (want_done) check("held_pass", 8'(pass0), 8'd1);
         if (t == 39) start0 = 1'b0;
      end
      // 5b: start pulse and exp_tt change mid-run are ignored
      run(0, TT_XOR, TT_XOR, 5, 1'b1);

      // randomized runs on both settle settings
      for (int r = 0; r < 6; r++)
         run(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1, 1'b0);

      // 6: zero settle cycles
      run(1, TT_XOR, TT_XOR, 1, 1'b0);
      run(1, TT_NOR, TT_XOR, 1, 1'b1);
      for (int r = 0; r < 4; r++)
         run(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
